// File: rtl/icache_mem_read_responder.sv
// Icache block-refill responder: fetches one aligned cache block as WBKSZ
// pipelined word reads and returns it as a single block with valid/ready.
//
// state    | meaning
// ST_IDLE  | ready for a block request
// ST_FETCH | issuing word reads and collecting beats in order
// ST_RESP  | block held on the response channel until accepted
module icache_mem_read_responder #(
    parameter int WDSZ      = 32,
    parameter int WBKSZ     = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WDSZ-1:0]        mem_read_req_addr,
    input  logic                   mem_read_req_valid,
    output logic                   mem_read_req_ready,
    output logic [WBKSZ*WDSZ-1:0]  mem_read_resp_data,
    output logic                   mem_read_resp_valid,
    input  logic                   mem_read_resp_ready,
    output logic                   mem_read_resp_err,
    output logic [WDSZ-1:0]        bus_araddr,
    output logic                   bus_arvalid,
    input  logic                   bus_arready,
    input  logic [WDSZ-1:0]        bus_rdata,
    input  logic                   bus_rerr,
    input  logic                   bus_rvalid,
    output logic                   bus_rready
);

    localparam int CW    = $clog2(WBKSZ) + 1;
    localparam int OFS_W = $clog2(WBKSZ * WDSZ / 8);

    localparam logic [WDSZ-1:0] WORD_BYTES = WDSZ'(WDSZ / 8);
    localparam logic [WDSZ-1:0] BLK_MASK   = ~((WDSZ'(1) << OFS_W) - WDSZ'(1));

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]             state_q;
    logic                   rst_done_q;
    logic [WDSZ-1:0]        base_q;
    logic [CW-1:0]          iss_cnt_q;
    logic [CW-1:0]          rcv_cnt_q;
    logic                   err_q;
    logic [WBKSZ*WDSZ-1:0]  data_q;
    logic [CW-1:0]          outst;
    logic                   accept;
    logic                   issue;
    logic                   beat;

    assign outst = iss_cnt_q - rcv_cnt_q;

    // rst_done_q keeps req_ready low until the first clock after reset release
    assign mem_read_req_ready  = (state_q == ST_IDLE) && rst_done_q;
    assign mem_read_resp_valid = (state_q == ST_RESP);
    assign mem_read_resp_err   = err_q;
    assign mem_read_resp_data  = data_q;

    assign bus_arvalid = (state_q == ST_FETCH) && (iss_cnt_q < CW'(WBKSZ))
                         && (outst < CW'(MAX_OUTST));
    assign bus_araddr  = base_q + WDSZ'(iss_cnt_q) * WORD_BYTES;
    assign bus_rready  = (state_q == ST_FETCH);

    assign accept = mem_read_req_valid && mem_read_req_ready;
    assign issue  = bus_arvalid && bus_arready;
    assign beat   = bus_rvalid && bus_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rst_done_q <= 1'b0;
            base_q     <= '0;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        base_q    <= mem_read_req_addr & BLK_MASK;
                        iss_cnt_q <= '0;
                        rcv_cnt_q <= '0;
                        err_q     <= 1'b0;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        iss_cnt_q <= iss_cnt_q + CW'(1);
                    end
                    if (beat) begin
                        rcv_cnt_q <= rcv_cnt_q + CW'(1);
                        err_q     <= err_q | bus_rerr;
                        if (rcv_cnt_q == CW'(WBKSZ - 1)) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem_read_resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Beats arrive in issue order, so the receive count selects the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < WBKSZ; i++) begin
                if (beat && (rcv_cnt_q == CW'(i))) begin
                    data_q[i*WDSZ +: WDSZ] <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_mem_read_responder.sv
// Bench for icache_mem_read_responder: randomized word-port stalls and
// addresses, checked against an arithmetic model of the expected block.
module tb_icache_mem_read_responder;

    localparam int WDSZ      = 32;
    localparam int WBKSZ     = 8;
    localparam int MAX_OUTST = 4;
    localparam int BW        = WDSZ * WBKSZ;
    localparam int BLK_BYTES = WBKSZ * WDSZ / 8;

    logic             clk;
    logic             rst_n;
    logic [WDSZ-1:0]  req_addr;
    logic             req_valid;
    logic             req_ready;
    logic [BW-1:0]    resp_data;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_err;
    logic [WDSZ-1:0]  bus_araddr;
    logic             bus_arvalid;
    logic             bus_arready;
    logic [WDSZ-1:0]  bus_rdata;
    logic             bus_rerr;
    logic             bus_rvalid;
    logic             bus_rready;

    icache_mem_read_responder #(
        .WDSZ(WDSZ), .WBKSZ(WBKSZ), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_read_req_addr   (req_addr),
        .mem_read_req_valid  (req_valid),
        .mem_read_req_ready  (req_ready),
        .mem_read_resp_data  (resp_data),
        .mem_read_resp_valid (resp_valid),
        .mem_read_resp_ready (resp_ready),
        .mem_read_resp_err   (resp_err),
        .bus_araddr          (bus_araddr),
        .bus_arvalid         (bus_arvalid),
        .bus_arready         (bus_arready),
        .bus_rdata           (bus_rdata),
        .bus_rerr            (bus_rerr),
        .bus_rvalid          (bus_rvalid),
        .bus_rready          (bus_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [WDSZ-1:0] mem_word(input logic [WDSZ-1:0] a);
        return a;
    endfunction

    function automatic logic [BW-1:0] exp_block(input logic [WDSZ-1:0] addr);
        logic [BW-1:0]   blk;
        logic [WDSZ-1:0] base;
        base = addr - (addr % BLK_BYTES);
        for (int i = 0; i < WBKSZ; i++) blk[i*WDSZ +: WDSZ] = mem_word(base + WDSZ'(4 * i));
        return blk;
    endfunction

    // Word-port model: in-order responses, optional random stalls
    logic [WDSZ-1:0] rq[$];
    bit              stall_en = 0;
    int              err_beat = -1;
    int              beats = 0;
    int              max_outst = 0;
    bit              addr_unstable = 0;
    bit              prev_stalled = 0;
    logic [WDSZ-1:0] prev_addr = '0;

    initial begin
        bus_arready = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;
        bus_rerr    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rq.delete();
                bus_arready  = 1'b0;
                bus_rvalid   = 1'b0;
                bus_rdata    = '0;
                bus_rerr     = 1'b0;
                prev_stalled = 0;
                continue;
            end
            if (prev_stalled && (!bus_arvalid || bus_araddr != prev_addr)) addr_unstable = 1;
            bus_rvalid = 1'b0;
            bus_rerr   = 1'b0;
            bus_rdata  = '0;
            if (rq.size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
                bus_rvalid = 1'b1;
                bus_rdata  = mem_word(rq[0]);
                bus_rerr   = (beats == err_beat);
                if (bus_rready) begin
                    void'(rq.pop_front());
                    beats++;
                end
            end
            bus_arready = !stall_en || ($urandom_range(0, 2) != 0);
            if (bus_arvalid && bus_arready) rq.push_back(bus_araddr);
            if (rq.size() > max_outst) max_outst = rq.size();
            prev_stalled = bus_arvalid && !bus_arready;
            prev_addr    = bus_araddr;
        end
    end

    task automatic send_req(input logic [WDSZ-1:0] addr, output int t_acc);
        int n;
        beats = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_accept_timeout", 0, 1);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int t_rv);
        int n;
        n = 0;
        while (!resp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        t_rv = cyc;
    endtask

    task automatic finish_resp();
        chk("req_ready_in_resp", req_ready, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("req_ready_after_resp", req_ready, 1);
        chk("resp_valid_after_resp", resp_valid, 0);
    endtask

    task automatic run_block(input logic [WDSZ-1:0] addr, input bit exp_err,
                             input bit check_lat, input string tag);
        int t_acc;
        int t_rv;
        send_req(addr, t_acc);
        wait_resp(t_rv);
        if (check_lat) chk({tag, "_latency"}, t_rv - t_acc, WBKSZ + 2);
        chk({tag, "_data"}, resp_data, exp_block(addr));
        chk({tag, "_err"}, resp_err, exp_err);
        finish_resp();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] held;
        int            t_acc;
        int            n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;

        #2;
        chk("reset_outputs", {req_ready, resp_valid, resp_err, bus_arvalid, bus_rready,
                              bus_araddr, resp_data}, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs_clocked", {req_ready, resp_valid, resp_err, bus_arvalid,
                                      bus_rready, bus_araddr, resp_data}, 0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_before_clock", req_ready, 0);
        @(negedge clk);
        chk("req_ready_first_clock", req_ready, 1);

        run_block(32'h0000_1234, 0, 1, "ref");

        // Response held off for 20 cycles
        send_req(32'h0000_2468, t_acc);
        wait_resp(n);
        held = resp_data;
        chk("hold_data", held, exp_block(32'h0000_2468));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_state", {resp_valid, req_ready, resp_data}, {1'b1, 1'b0, held});
        end
        finish_resp();

        err_beat = 5;
        run_block(32'h0000_0808, 1, 1, "err_block");
        err_beat = -1;
        run_block(32'h0000_0A0C, 0, 1, "clean_block");

        run_block(32'hFFFF_FFF0, 0, 1, "top_block");
        run_block(32'h0000_0000, 0, 1, "zero_block");

        stall_en      = 1;
        max_outst     = 0;
        addr_unstable = 0;
        run_block(32'h0000_1234, 0, 0, "stall_ref");
        for (int i = 0; i < 6; i++) begin
            run_block(WDSZ'($urandom), 0, 0, "stall_rand");
        end
        chk("max_outstanding_ok", max_outst <= MAX_OUTST, 1);
        chk("araddr_stable", addr_unstable, 0);
        stall_en = 0;

        // Reset mid-fetch after three received beats
        send_req(32'h0000_0100, t_acc);
        n = 0;
        while (beats < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (beats < 3) chk("beat_wait_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midfetch_reset_outputs", {req_ready, resp_valid, resp_err, bus_arvalid,
                                       bus_rready, bus_araddr, resp_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(32'h0000_0040, 0, 1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
